// File: rtl/bus_arb_pkg.sv
// Shared state encodings and width helpers for the N-master bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arbState_t;

    function automatic int mselWidth(input int numMasters);
        return (numMasters > 1) ? $clog2(numMasters) : 1;
    endfunction

    // The tenure counter never needs to reach MAX_HOLD itself, but keep one spare code.
    function automatic int holdCntWidth(input int maxHold);
        return (maxHold > 0) ? $clog2(maxHold + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Rotating priority encoder: the first set request at or after i_start wins,
// with the search wrapping around past the highest index.
module arb_priority_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int MSEL_W      = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [MSEL_W-1:0]      i_start,
    output logic [NUM_MASTERS-1:0] o_oneHot,
    output logic [MSEL_W-1:0]      o_index,
    output logic                   o_valid
);

    localparam logic [MSEL_W:0] N_WIDE = (MSEL_W+1)'(NUM_MASTERS);

    logic [2*NUM_MASTERS-1:0] w_reqTwice;
    logic [NUM_MASTERS-1:0]   w_reqRot;
    logic [NUM_MASTERS-1:0]   w_scan;
    logic [MSEL_W-1:0]        w_offset;
    logic [MSEL_W:0]          w_sum;
    logic                     w_found;

    // Rotate so the start index sits at bit 0; the doubled copy supplies the wrap.
    assign w_reqTwice = {i_req, i_req} >> i_start;
    assign w_reqRot   = w_reqTwice[NUM_MASTERS-1:0];

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        w_scan   = w_reqRot;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_found && w_scan[0]) begin
                w_found  = 1'b1;
                w_offset = MSEL_W'(k);
            end
            w_scan = w_scan >> 1;
        end
        w_sum = {1'b0, i_start} + {1'b0, w_offset};
    end

    assign o_valid  = w_found;
    assign o_index  = (w_sum >= N_WIDE) ? MSEL_W'(w_sum - N_WIDE) : w_sum[MSEL_W-1:0];
    assign o_oneHot = w_found ? (NUM_MASTERS'(1) << o_index) : '0;

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter with slave-ready wait state and optional tenure timeout.
// Define BUS_ARB_ROUND_ROBIN_EN for rotating priority; otherwise master 0 always wins.
module bus_arbiter_n
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 3,
    parameter int MAX_HOLD    = 0,
    parameter int MSEL_W      = mselWidth(NUM_MASTERS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_MASTERS-1:0] i_breq,
    input  logic [NUM_SLAVES-1:0]  i_sready,
    output logic [NUM_MASTERS-1:0] o_bgrant,
    output logic [MSEL_W-1:0]      o_msel,
    output logic                   o_bus_busy,
    output logic                   o_hold_expired
);

    localparam int              CNT_W    = holdCntWidth(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    arbState_t              r_state,       w_stateNext;
    logic [MSEL_W-1:0]      r_owner,       w_ownerNext;
    logic [NUM_MASTERS-1:0] r_grantVec,    w_grantVecNext;
    logic [CNT_W-1:0]       r_holdCnt,     w_holdCntNext;
    logic                   r_holdExpired, w_holdExpiredNext;

    logic                   w_arbitrate;
    logic                   w_ownerReq;
    logic [MSEL_W-1:0]      w_start;
    logic [NUM_MASTERS-1:0] w_winOneHot;
    logic [MSEL_W-1:0]      w_winIndex;
    logic                   w_winValid;

    // r_grantVec mirrors r_owner in one-hot form so the owner's request needs no index decode.
    assign w_ownerReq = |(i_breq & r_grantVec);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam logic [MSEL_W-1:0] OWNER_LAST = MSEL_W'(NUM_MASTERS - 1);

    logic [MSEL_W-1:0] r_rrStart;
    logic              w_tenureEnd;

    assign w_tenureEnd = (r_state == GRANT) && (w_stateNext == WAIT);
    assign w_start     = r_rrStart;

    // The pointer moves past the owner only when its tenure actually ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rrStart <= '0;
        end else if (w_tenureEnd) begin
            r_rrStart <= (r_owner == OWNER_LAST) ? '0 : r_owner + 1'b1;
        end
    end
`else
    assign w_start = '0;
`endif

    arb_priority_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .MSEL_W     (MSEL_W)
    ) u_pick (
        .i_req   (i_breq),
        .i_start (w_start),
        .o_oneHot(w_winOneHot),
        .o_index (w_winIndex),
        .o_valid (w_winValid)
    );

    always_comb begin
        w_stateNext       = r_state;
        w_ownerNext       = r_owner;
        w_grantVecNext    = r_grantVec;
        w_holdCntNext     = r_holdCnt;
        w_holdExpiredNext = 1'b0;
        w_arbitrate       = 1'b0;
        case (r_state)
            IDLE: w_arbitrate = 1'b1;
            GRANT: begin
                if (!w_ownerReq) begin
                    w_stateNext = WAIT;
                end else if ((MAX_HOLD > 0) && (r_holdCnt == CNT_LAST)) begin
                    w_stateNext       = WAIT;
                    w_holdExpiredNext = 1'b1;
                end else if (r_holdCnt != CNT_LAST) begin
                    w_holdCntNext = r_holdCnt + 1'b1;
                end
            end
            WAIT:    w_arbitrate = &i_sready;
            default: w_stateNext = IDLE;
        endcase
        if (w_arbitrate) begin
            if (w_winValid) begin
                w_stateNext    = GRANT;
                w_ownerNext    = w_winIndex;
                w_grantVecNext = w_winOneHot;
                w_holdCntNext  = '0;
            end else begin
                w_stateNext = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_grantVec    <= '0;
            r_holdCnt     <= '0;
            r_holdExpired <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_owner       <= w_ownerNext;
            r_grantVec    <= w_grantVecNext;
            r_holdCnt     <= w_holdCntNext;
            r_holdExpired <= w_holdExpiredNext;
        end
    end

    assign o_bgrant       = (r_state == GRANT) ? r_grantVec : '0;
    assign o_msel         = r_owner;
    assign o_bus_busy     = (r_state != IDLE);
    assign o_hold_expired = r_holdExpired;

endmodule

// File: doc/bus_arbiter_n.md
# bus_arbiter_n

Parametrised N-master bus arbiter for the system bus, successor to the two-master fixed-priority arbiter. Grants the shared bus to one of `NUM_MASTERS` requesters, drives the master-select mux index, and holds the bus in a wait state after each release until every slave reports ready. Adds selectable round-robin fairness and a bounded-tenure timeout that force-releases a master holding the bus too long.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesting masters, ≥2.
- `NUM_SLAVES`, 3: number of slave ready inputs, ≥1.
- `MAX_HOLD`, 0: maximum consecutive grant cycles per tenure; 0 disables the timeout.
- `MSEL_W`, `$clog2(NUM_MASTERS)`: width of `msel`; derived, never overridden.

Ports:
- `clk` in 1: bus clock; one clock domain, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `breq` in `NUM_MASTERS`: bus request, bit i from master i; level-held for the whole transfer.
- `sready` in `NUM_SLAVES`: slave ready; the bus is free only when all bits are 1.
- `bgrant` out `NUM_MASTERS`: one-hot grant, or all zero.
- `msel` out `MSEL_W`: index of the granted master; holds the last owner when no master is granted.
- `bus_busy` out 1: 1 in any state other than IDLE.
- `hold_expired` out 1: one-cycle pulse in the cycle a tenure is ended by the timeout.

## Operation
- States: IDLE, GRANT, WAIT. `owner` register holds the current or last granted index.
- Arbitration runs in IDLE, and in WAIT once all `sready` bits are 1. Any `breq` set: go to GRANT with `owner` set to the winner. No `breq` set: go to IDLE.
- Fixed priority (default): the lowest requesting index wins.
- GRANT: `bgrant[owner]`=1 and `msel`=`owner`.
  - Stay in GRANT while `breq[owner]` is 1 and the timeout has not fired.
  - `breq[owner]` drops: go to WAIT.
- Timeout (`MAX_HOLD`>0): `hold_cnt` clears on entry to GRANT and increments each GRANT cycle.
  - When `hold_cnt`==`MAX_HOLD`-1 and `breq[owner]` is still 1, go to WAIT and pulse `hold_expired`.
  - The force-released master may re-request. Under fixed priority it may win again.
- WAIT: `bgrant`=0. Stay in WAIT while any `sready` bit is 0, and spend at least 1 cycle there.
- Requests arriving during GRANT or WAIT are not lost. They are evaluated at the next arbitration point.
- `bgrant` is never asserted in IDLE or WAIT. At most one bit is ever set.

## Timing
- Reset values: state=IDLE, `owner`=0, `hold_cnt`=0, `bgrant`=0, `msel`=0, `bus_busy`=0, `hold_expired`=0. With round-robin compiled in, the priority pointer resets so master 0 has highest priority.
- `rst` mid-tenure: at the next edge all grants drop and every register returns to its reset value.
- Outputs are Moore outputs decoded from registered state and `owner`. There are no combinational paths from inputs to outputs.
- Grant latency: `breq` first seen high at edge k gives `bgrant` high after edge k (1 cycle).
- Release: `breq[owner]` seen low at edge k gives `bgrant` low after edge k, and the state is WAIT.
- Back-to-back handover: with `sready` all 1, a new grant follows release after exactly 1 WAIT cycle.
- Timeout: with `breq` held and `MAX_HOLD`=M, the master gets exactly M grant cycles.
  - `hold_expired` is high during the first WAIT cycle.
- Counter width: `hold_cnt` is `$clog2(MAX_HOLD+1)` bits, minimum 1, and never wraps.

## Configuration
- `BUS_ARB_ROUND_ROBIN_EN` defined: rotating priority.
  - The search starts at (`owner`+1) mod `NUM_MASTERS` and wraps around.
  - The pointer advances only when a tenure ends, whether by release or by timeout.
- Not defined: fixed priority, master 0 highest. There is no pointer logic, and behaviour matches the two-master predecessor when `NUM_MASTERS`=2 and `MAX_HOLD`=0.

## Structure
- Package `bus_arb_pkg`: state encodings (IDLE=2'd0, GRANT=2'd1, WAIT=2'd2) and the `msel` width helper function.
- Sub-module `arb_priority_pick`: combinational rotating priority encoder.
  - Inputs: request vector and start index.
  - Outputs: one-hot winner, binary index, and a valid flag.
  - Fixed-priority mode ties the start index to 0.

## Test plan
- Reset, then `breq`=4'b0110 with all `sready`=1 → after 1 edge `bgrant`=4'b0010, `msel`=1. Drop `breq[1]` → 1 WAIT cycle, then `bgrant`=4'b0100, `msel`=2.
- `sready`=3'b101 while master 0 releases → stays in WAIT with `bgrant`=0 until `sready`=3'b111. Regrant happens on the following edge.
- Round-robin, all four `breq` held high, `MAX_HOLD`=3 → grants rotate in the order 0,1,2,3,0. Each tenure is 3 cycles, and `hold_expired` pulses each time.
- Fixed priority, `breq`=4'b1001 held, `MAX_HOLD`=2 → master 0 is regranted after every WAIT and master 3 is never granted. This starvation is the documented behaviour.
- `rst` asserted mid-GRANT of master 2 → next edge gives `bgrant`=0, `msel`=0, `bus_busy`=0. With `breq[2]` still held after reset deasserts, the regrant takes 1 cycle.
- `breq`=0 for 10 cycles → state stays IDLE, all outputs 0, and no `hold_expired` pulse.
